fifo_sync_param: RTL
====================

// Module: fifo_sync_param
// PURPOSE
// - Parametrised synchronous FIFO; successor to the fixed 16x8 FIFO.
// - Width, depth and almost-thresholds are configurable. Exposes a live occupancy count.
// - Defines deterministic rules for simultaneous read and write at the full and empty boundaries.
// - Sits between a producer and a consumer in one clock domain; consumed by TEST/MON-style benches.
// PARAMETERS
// - FIFO_WIDTH  16            data word width, >=1
// - FIFO_DEPTH  8             number of entries, >=2; need not be a power of two
// - AF_THRESH   FIFO_DEPTH-1  almostfull asserts when count == AF_THRESH
// - AE_THRESH   1             almostempty asserts when count == AE_THRESH
// PORTS
// - clk          in   1             single clock, rising edge
// - rst          in   1             synchronous, active-high reset
// - data_in      in   FIFO_WIDTH    write data
// - wr_en        in   1             write request
// - rd_en        in   1             read request
// - data_out     out  FIFO_WIDTH    registered read data
// - wr_ack       out  1             registered; previous-cycle write accepted
// - overflow     out  1             registered; previous-cycle write rejected (full)
// - underflow    out  1             registered; previous-cycle read rejected (empty)
// - full         out  1             combinational: count == FIFO_DEPTH
// - empty        out  1             combinational: count == 0
// - almostfull   out  1             combinational: count == AF_THRESH
// - almostempty  out  1             combinational: count == AE_THRESH
// - count        out  CW            occupancy, CW = $clog2(FIFO_DEPTH+1)
// BEHAVIOUR
// - Reset (rst=1 at an edge):
//   - wr_ptr, rd_ptr, count -> 0; data_out, wr_ack, overflow, underflow -> 0.
//   - Memory contents are not cleared. Reset mid-operation discards all stored words.
// - Write accepted when wr_en && (!full || rd_en accepted this cycle is NOT credited; see below).
//   - On accept: mem[wr_ptr] <= data_in; wr_ack <= 1 next cycle.
//   - On reject: wr_ack <= 0 and overflow <= 1 next cycle.
// - Read accepted when rd_en && !empty.
//   - data_out <= mem[rd_ptr]; 1-cycle latency; data_out holds its value when no read occurs.
//   - On reject: underflow <= 1 next cycle; data_out unchanged.
// - Pointers wrap explicitly: ptr == FIFO_DEPTH-1 -> 0 (no power-of-two dependence).
// - Simultaneous wr_en && rd_en:
//   - Not full and not empty: both accepted; count unchanged.
//   - empty: write accepted, read rejected (underflow=1); count +1.
//   - full: read accepted, write rejected (overflow=1); count -1.
// - count: +1 on write only, -1 on read only, otherwise held.
//   - Never exceeds FIFO_DEPTH; never wraps below 0.
// - wr_ack, overflow and underflow are single-cycle pulses per request; deasserted when there is no request.
// - Parameter check: elaboration $error if AF_THRESH>FIFO_DEPTH or AE_THRESH>=FIFO_DEPTH.
// CONFIGURATION
// - Macro FIFO_HWM_EN, when defined:
//   - Adds input hwm_clr (1 bit) and output hwm (CW bits).
//   - hwm tracks the maximum count since reset or hwm_clr.
//   - hwm resets to 0. hwm_clr loads the current count, and takes priority over the update.
// - Without FIFO_HWM_EN: those ports and registers are absent; all other behaviour is identical.
// STRUCTURE
// - Package fifo_pkg:
//   - Default width/depth localparams.
//   - function automatic ptr_inc(ptr, depth) for explicit wrap.
//   - typedef fifo_status_t: packed struct {full, empty, almostfull, almostempty}.
// - Sub-module fifo_mem: FIFO_WIDTH x FIFO_DEPTH array, 1 write port, 1 registered read port.
// - Top holds pointers, count, flags and HWM logic.
// STRUCTURE (continued)
// - The interface successor carries count and the optional HWM ports under the same macro.
// TESTING (FIFO_WIDTH=16, FIFO_DEPTH=8, defaults)
// - Reset then idle 2 cycles:
//   -> empty=1, full=0, count=0, data_out=0, wr_ack=overflow=underflow=0.
// - Write 0x0001..0x0008 on 8 cycles:
//   -> wr_ack=1 each next cycle; almostfull at count=7; full=1 at count=8.
//   - A 9th write of 0xDEAD -> overflow=1, wr_ack=0, count stays 8.
// - From full, wr_en=rd_en=1 with data 0xBEEF:
//   -> data_out=0x0001 next cycle, overflow=1, count=7.
//   - Then a read of all 7 returns 0x0002..0x0008 with no 0xBEEF.
// - From empty, wr_en=rd_en=1 with 0x00AA:
//   -> underflow=1, wr_ack=1, count=1; the next read returns 0x00AA.
// - Wrap: 20 cycles of concurrent read/write at count=4 with incrementing data:
//   -> output order preserved across pointer wrap; count constant 4.
// - Assert rst with count=5 mid-burst:
//   -> next cycle count=0, empty=1, flags 0.
//   - With FIFO_HWM_EN: hwm=0 after reset, hwm=5 after refilling to 5, and hwm_clr at count=2 gives hwm=2.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults, status bundle and pointer-wrap helper for the parametrised sync FIFO.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
  } fifo_status_t;

  // Explicit wrap so depths that are not a power of two behave correctly.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one write port, one registered read port. Array contents survive reset;
// only the read register is cleared.
module fifo_mem #(
  parameter int  WIDTH = 16,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy count and boundary-safe simultaneous access.
// Optional high-water mark (hwm/hwm_clr) is built when FIFO_HWM_EN is defined.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int  FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int  AF_THRESH  = FIFO_DEPTH - 1,
  parameter int  AE_THRESH  = 1,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
`ifdef FIFO_HWM_EN
  ,
  input  logic                  hwm_clr,
  output logic [CW-1:0]         hwm
`endif
);

  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (AF_THRESH > FIFO_DEPTH || AE_THRESH >= FIFO_DEPTH) begin : g_param_err
    $error("fifo_sync_param: AF_THRESH must be <= FIFO_DEPTH and AE_THRESH < FIFO_DEPTH");
  end

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok, rd_ok;
  fifo_status_t  status;

  always_comb begin
    status.full        = (count == DEPTH_C);
    status.empty       = (count == '0);
    status.almostfull  = (count == AF_C);
    status.almostempty = (count == AE_C);
  end

  assign full        = status.full;
  assign empty       = status.empty;
  assign almostfull  = status.almostfull;
  assign almostempty = status.almostempty;

  // A read in the same cycle does not free a slot for a write at full, and a write
  // does not supply data for a read at empty.
  assign wr_ok = wr_en & ~status.full  & ~rst;
  assign rd_ok = rd_en & ~status.empty & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), 32'(FIFO_DEPTH)));
      if (rd_ok) rd_ptr <= PW'(ptr_inc(32'(rd_ptr), 32'(FIFO_DEPTH)));
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      wr_ack    <= wr_ok;
      overflow  <= wr_en & ~wr_ok;
      underflow <= rd_en & ~rd_ok;
    end
  end

`ifdef FIFO_HWM_EN
  always_ff @(posedge clk) begin
    if (rst)              hwm <= '0;
    else if (hwm_clr)     hwm <= count;
    else if (count > hwm) hwm <= count;
  end
`endif

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule
